// File: rtl/fpu_shared_arbiter.sv
// Round-robin sharing of one fixed-latency FP32 FPU among NUM_REQ requesters.
// A {valid, illegal, id} tag pipeline routes each result back to its issuer.
module fpu_shared_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RI,
    input  logic [NUM_REQ-1:0]      Req_SI,
    input  logic [NUM_REQ*32-1:0]   OpA_DI,
    input  logic [NUM_REQ*32-1:0]   OpB_DI,
    input  logic [NUM_REQ*4-1:0]    Cmd_DI,
    input  logic [NUM_REQ*3-1:0]    RM_DI,
    output logic [NUM_REQ-1:0]      Gnt_SO,
    output logic [NUM_REQ-1:0]      RespValid_SO,
    output logic [31:0]             Result_DO,
    output logic [4:0]              Flags_DO,
    output logic                    FpuEn_SO,
    output logic [31:0]             FpuOpA_DO,
    output logic [31:0]             FpuOpB_DO,
    output logic [3:0]              FpuCmd_DO,
    output logic [2:0]              FpuRM_DO,
    input  logic [31:0]             FpuResult_DI,
    input  logic [4:0]              FpuFlags_DI
);

    localparam logic [3:0]  CMD_MUL = 4'b0001;
    localparam logic [3:0]  CMD_ADD = 4'b0010;
    localparam logic [3:0]  CMD_SUB = 4'b0011;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [4:0]  FLAG_NV = 5'b10000;
    localparam int          LAST    = LATENCY - 1;

    logic [31:0] op_a [NUM_REQ];
    logic [31:0] op_b [NUM_REQ];
    logic [3:0]  cmd  [NUM_REQ];
    logic [2:0]  rm   [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi] = OpA_DI[gi*32 +: 32];
            assign op_b[gi] = OpB_DI[gi*32 +: 32];
            assign cmd[gi]  = Cmd_DI[gi*4 +: 4];
            assign rm[gi]   = RM_DI[gi*3 +: 3];
        end
    endgenerate

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      win_id;
    logic                 gnt_any;
    logic                 win_legal;
    logic [2*NUM_REQ-1:0] req_rot;
    int                   win_off;
    int                   win_sum;

    logic                 vld_q [LATENCY];
    logic                 vld_d [LATENCY];
    logic                 ill_q [LATENCY];
    logic                 ill_d [LATENCY];
    logic [ID_W-1:0]      id_q  [LATENCY];
    logic [ID_W-1:0]      id_d  [LATENCY];

    // Rotating the doubled request vector by PTR makes bit k the requester k places after PTR.
    always_comb begin : arbitrate
        req_rot = {Req_SI, Req_SI} >> ptr_q;
        gnt_any = 1'b0;
        win_off = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && req_rot[k]) begin
                gnt_any = 1'b1;
                win_off = k;
            end
        end
        win_sum = int'(ptr_q) + win_off;
        win_id  = ID_W'((win_sum >= NUM_REQ) ? (win_sum - NUM_REQ) : win_sum);
        if (Rst_RI) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin : ptr_next
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_comb begin : issue
        win_legal = (cmd[win_id] == CMD_MUL) || (cmd[win_id] == CMD_ADD) ||
                    (cmd[win_id] == CMD_SUB);
        Gnt_SO    = '0;
        FpuEn_SO  = 1'b0;
        FpuOpA_DO = '0;
        FpuOpB_DO = '0;
        FpuCmd_DO = '0;
        FpuRM_DO  = '0;
        if (gnt_any) begin
            Gnt_SO[win_id] = 1'b1;
            FpuEn_SO       = win_legal;
            FpuOpA_DO      = op_a[win_id];
            FpuOpB_DO      = op_b[win_id];
            FpuCmd_DO      = cmd[win_id];
            FpuRM_DO       = rm[win_id];
        end
    end

    always_comb begin : tag_next
        vld_d[0] = gnt_any;
        ill_d[0] = gnt_any & ~win_legal;
        id_d[0]  = win_id;
        for (int s = 1; s < LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
            ill_d[s] = ill_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

    always_ff @(posedge Clk_CI) begin : state_reg
        if (Rst_RI) begin
            ptr_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                vld_q[s] <= 1'b0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int s = 0; s < LATENCY; s++) begin
                vld_q[s] <= vld_d[s];
            end
        end
        for (int s = 0; s < LATENCY; s++) begin
            ill_q[s] <= ill_d[s];
            id_q[s]  <= id_d[s];
        end
    end

    // Illegal entries never touched the FPU, so their answer is synthesised here.
    always_comb begin : respond
        RespValid_SO = '0;
        Result_DO    = '0;
        Flags_DO     = '0;
        if (vld_q[LAST] && !Rst_RI) begin
            RespValid_SO[id_q[LAST]] = 1'b1;
            if (ill_q[LAST]) begin
                Result_DO = QNAN;
                Flags_DO  = FLAG_NV;
            end else begin
                Result_DO = FpuResult_DI;
                Flags_DO  = FpuFlags_DI;
            end
        end
    end

endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// Directed bench for fpu_shared_arbiter: a stub FPU of matching latency plus a
// scoreboard of expected responses filled at grant time and drained per cycle.
module tb_fpu_shared_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    localparam logic [3:0] MUL = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0011;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req;
    logic [N*32-1:0] opa_bus, opb_bus;
    logic [N*4-1:0]  cmd_bus;
    logic [N*3-1:0]  rm_bus;
    logic [N-1:0]    gnt, resp_valid;
    logic [31:0]     result;
    logic [4:0]      flags;
    logic            fpu_en;
    logic [31:0]     fpu_opa, fpu_opb, fpu_result;
    logic [3:0]      fpu_cmd;
    logic [2:0]      fpu_rm;
    logic [4:0]      fpu_flags;

    logic [31:0] opa [N];
    logic [31:0] opb [N];
    logic [3:0]  cmd [N];
    logic [2:0]  rm  [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign opa_bus[gi*32 +: 32] = opa[gi];
            assign opb_bus[gi*32 +: 32] = opb[gi];
            assign cmd_bus[gi*4 +: 4]   = cmd[gi];
            assign rm_bus[gi*3 +: 3]    = rm[gi];
        end
    endgenerate

    fpu_shared_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .Req_SI      (req),
        .OpA_DI      (opa_bus),
        .OpB_DI      (opb_bus),
        .Cmd_DI      (cmd_bus),
        .RM_DI       (rm_bus),
        .Gnt_SO      (gnt),
        .RespValid_SO(resp_valid),
        .Result_DO   (result),
        .Flags_DO    (flags),
        .FpuEn_SO    (fpu_en),
        .FpuOpA_DO   (fpu_opa),
        .FpuOpB_DO   (fpu_opb),
        .FpuCmd_DO   (fpu_cmd),
        .FpuRM_DO    (fpu_rm),
        .FpuResult_DI(fpu_result),
        .FpuFlags_DI (fpu_flags)
    );

    // Bit-exact for the directed operand pairs, a scrambled but deterministic value otherwise.
    function automatic logic [36:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        if (c == ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, 5'b0};
        if (c == ADD && a == 32'h3F80_0000 && b == 32'h3F80_0000) return {32'h4000_0000, 5'b0};
        if (c == MUL && a == 32'h4000_0000 && b == 32'h4040_0000) return {32'h40C0_0000, 5'b0};
        if (c == SUB && a == 32'h40A0_0000 && b == 32'h3FC0_0000) return {32'h4060_0000, 5'b0};
        return {a ^ {b[15:0], b[31:16]} ^ {28'h0, c}, a[4:0] ^ b[9:5]};
    endfunction

    // Stub FPU: never reset, so stale results keep flowing after a reset.
    logic [36:0] fpu_pipe [LAT];
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_en ? fpu_fn(fpu_opa, fpu_opb, fpu_cmd) : {32'hDEAD_BEEF, 5'b01010};
        for (int s = 1; s < LAT; s++) begin
            fpu_pipe[s] <= fpu_pipe[s-1];
        end
    end
    assign fpu_result = fpu_pipe[LAT-1][36:5];
    assign fpu_flags  = fpu_pipe[LAT-1][4:0];

    typedef struct {
        int          due;
        int          id;
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    endtask

    // One clock: drive reset/requests, then check the response side and the grant side.
    task automatic tick(input logic r, input logic [N-1:0] rq, input int exp_w);
        exp_t        e;
        logic        legal;
        logic [36:0] rf;
        @(posedge clk);
        cyc++;
        #1;
        rst = r;
        req = rq;
        if (r) sb.delete();
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("resp_valid", 64'(resp_valid), 64'(1) << e.id);
            chk("resp_result", 64'(result), 64'(e.res));
            chk("resp_flags", 64'(flags), 64'(e.flg));
        end else begin
            chk("no_resp", 64'(resp_valid), 64'(0));
            chk("idle_result", 64'({result, flags}), 64'(0));
        end
        if (exp_w < 0) begin
            chk("no_gnt", 64'(gnt), 64'(0));
            chk("idle_fpu", 64'({fpu_en, fpu_opa}), 64'(0));
        end else begin
            legal = (cmd[exp_w] == MUL) || (cmd[exp_w] == ADD) || (cmd[exp_w] == SUB);
            chk("gnt", 64'(gnt), 64'(1) << exp_w);
            chk("fpu_en", 64'(fpu_en), 64'(legal));
            if (legal) begin
                chk("fpu_ops", {fpu_opa, fpu_opb}, {opa[exp_w], opb[exp_w]});
                chk("fpu_cmd_rm", 64'({fpu_cmd, fpu_rm}), 64'({cmd[exp_w], rm[exp_w]}));
                rf = fpu_fn(opa[exp_w], opb[exp_w], cmd[exp_w]);
            end else begin
                rf = {32'h7FC0_0000, 5'b10000};
            end
            sb.push_back('{due: cyc + LAT, id: exp_w, res: rf[36:5], flg: rf[4:0]});
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0; opb[i] = '0; cmd[i] = ADD; rm[i] = '0;
        end

        // Reset holds grants and responses low even with requests present
        tick(1'b1, 4'b1111, -1);
        tick(1'b1, 4'b1111, -1);

        // Single request from requester 2: ADD 1.0 + 2.0
        opa[2] = 32'h3F80_0000; opb[2] = 32'h4000_0000; cmd[2] = ADD; rm[2] = 3'd0;
        tick(1'b0, 4'b0100, 2);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);

        // Pointer wrap/skip: PTR = 3, requesters 1 and 3
        opa[1] = 32'h3F80_0000; opb[1] = 32'h3F80_0000; cmd[1] = ADD; rm[1] = 3'd1;
        opa[3] = 32'h40A0_0000; opb[3] = 32'h3FC0_0000; cmd[3] = SUB; rm[3] = 3'd2;
        tick(1'b0, 4'b1010, 3);
        tick(1'b0, 4'b0010, 1);
        tick(1'b0, 4'b0110, 2);
        tick(1'b0, 4'b0010, 1);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);

        // Illegal command from requester 0
        opa[0] = 32'h1234_5678; opb[0] = 32'h9ABC_DEF0; cmd[0] = 4'b0100; rm[0] = 3'd3;
        tick(1'b0, 4'b0001, 0);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);

        // Round-robin fairness from reset, all four requesting
        tick(1'b1, 4'b0000, -1);
        for (int i = 0; i < N; i++) begin
            opa[i] = $urandom; opb[i] = $urandom; rm[i] = 3'($urandom_range(0, 4));
            cmd[i] = (i % 3 == 0) ? ADD : ((i % 3 == 1) ? MUL : SUB);
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 4'b1111, k % N);
        end
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);

        // Back-to-back tag integrity: MUL@1, SUB@3, ADD@1
        opa[1] = 32'h4000_0000; opb[1] = 32'h4040_0000; cmd[1] = MUL; rm[1] = 3'd0;
        opa[3] = 32'h40A0_0000; opb[3] = 32'h3FC0_0000; cmd[3] = SUB; rm[3] = 3'd1;
        tick(1'b0, 4'b0010, 1);
        tick(1'b0, 4'b1000, 3);
        opa[1] = 32'h0F0F_1234; opb[1] = 32'h7777_0001; cmd[1] = ADD; rm[1] = 3'd4;
        tick(1'b0, 4'b0010, 1);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);

        // Reset one cycle after two issues; nothing may come back, PTR restarts at 0
        cmd[0] = MUL; cmd[2] = ADD;
        tick(1'b0, 4'b0001, 0);
        tick(1'b0, 4'b0100, 2);
        tick(1'b1, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b1001, 0);
        tick(1'b0, 4'b1000, 3);
        tick(1'b0, 4'b0000, -1);
        tick(1'b0, 4'b0000, -1);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fpu_shared_arbiter.md
Name: fpu_shared_arbiter

Overview:
- Shares one fixed-latency FP32 FPU datapath (ADD/SUB/MUL) among NUM_REQ requesters.
- Arbitration is round-robin: at most one operation issues per cycle.
- Each in-flight operation carries its requester ID through a LATENCY-deep tag pipeline, so every result returns to the requester that issued it.
- Illegal commands never reach the FPU; they are answered locally with a quiet NaN after the same latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, FPU cycles from operand issue to result valid (1..4).
- ID_W, $clog2(NUM_REQ), width of requester tag.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset.
- Req_SI  in  NUM_REQ  per-requester request.
- OpA_DI  in  NUM_REQ*32  operand A per requester (slice i = requester i).
- OpB_DI  in  NUM_REQ*32  operand B per requester.
- Cmd_DI  in  NUM_REQ*4  command per requester (0001 MUL, 0010 ADD, 0011 SUB).
- RM_DI  in  NUM_REQ*3  rounding mode per requester.
- Gnt_SO  out  NUM_REQ  one-hot grant, combinational, same cycle as request.
- RespValid_SO  out  NUM_REQ  one-hot response valid.
- Result_DO  out  32  result, shared bus, qualified by RespValid_SO.
- Flags_DO  out  5  {NV,DZ,OF,UF,NX}, qualified by RespValid_SO.
- FpuEn_SO  out  1  FPU issue strobe.
- FpuOpA_DO  out  32  operand A to the FPU.
- FpuOpB_DO  out  32  operand B to the FPU.
- FpuCmd_DO  out  4  command to the FPU.
- FpuRM_DO  out  3  rounding mode to the FPU.
- FpuResult_DI  in  32  FPU result, valid LATENCY cycles after FpuEn_SO.
- FpuFlags_DI  in  5  FPU flags, aligned with FpuResult_DI.

Behaviour:
- Reset values:
  - RR pointer = 0; all tag-pipeline valid bits = 0.
  - Gnt_SO = 0, RespValid_SO = 0, FpuEn_SO = 0.
  - Result_DO = 0, Flags_DO = 0.
- Arbitration:
  - Search starts at requester PTR and proceeds PTR, PTR+1, ... with modulo NUM_REQ wrap.
  - The first asserted Req_SI wins and gets Gnt_SO[i] = 1 in the same cycle.
  - When a grant occurs, PTR <= winner+1 (wrapping NUM_REQ-1 -> 0) at the clock edge. With no request, PTR holds.
  - A requester holds Req/operands until granted. Grant is never withheld when any request is present (no backpressure; responses cannot stall).
- Issue (grant cycle), legal command (ADD, SUB, MUL):
  - FpuEn_SO = 1; FpuOpA/OpB/Cmd/RM are driven combinationally from the winner's slice.
- Issue (grant cycle), illegal command (any other Cmd value):
  - Still granted, but FpuEn_SO = 0 and the tag entry is marked illegal.
- When no request is present, the Fpu* data outputs are don't-care; they are driven 0.
- Tag pipeline:
  - LATENCY-stage shift register of {valid, illegal, ID}, advanced every cycle.
  - Stage 0 is loaded at the grant edge.
- Response: when the last stage is valid, RespValid_SO[ID] = 1 for exactly one cycle.
  - For a legal entry, Result_DO and Flags_DO pass FpuResult_DI / FpuFlags_DI through.
  - For an illegal entry, Result_DO = 32'h7FC00000 and Flags_DO = 5'b10000 (NV).
- Throughput and latency:
  - One issue per cycle, back-to-back.
  - Grant at cycle T gives the response in cycle T+LATENCY.
  - Up to LATENCY operations are in flight.
- Simultaneous events: a new grant and a response to the same requester in the same cycle are legal and independent.
- Reset mid-operation:
  - All in-flight tags are dropped and no RespValid_SO follows.
  - FPU results arriving after reset are ignored.

Test Plan:
- Single request:
  - Stimulus: only requester 2; ADD 3F800000 + 40000000, RM 0.
  - Required: Gnt_SO = 0100 in the same cycle, FpuEn_SO = 1, FpuCmd_DO = 0010.
  - Required: after LATENCY cycles, RespValid_SO = 0100 and Result_DO = 40400000 (FPU model).
- Round-robin fairness:
  - Stimulus: all 4 requesting continuously for 8 cycles from reset.
  - Required: grant order 0, 1, 2, 3, 0, 1, 2, 3.
  - Required: responses arrive in the same order, each LATENCY later.
- Pointer wrap/skip:
  - Stimulus: PTR = 3; requesters 1 and 3 request.
  - Required: 3 is granted, PTR becomes 0; next cycle 1 is granted, PTR becomes 2.
- Illegal command:
  - Stimulus: requester 0 sends Cmd = 0100.
  - Required: granted, FpuEn_SO = 0.
  - Required: after LATENCY, RespValid_SO = 0001, Result_DO = 7FC00000, Flags_DO = 10000.
- Back-to-back tag integrity:
  - Stimulus: MUL from 1, then SUB from 3, then ADD from 1 in consecutive cycles.
  - Required: each result and its flags are routed to the matching requester in issue order.
  - Required: no dropped or duplicated RespValid_SO pulses.
- Reset mid-flight:
  - Stimulus: assert Rst_RI one cycle after two issues.
  - Required: no RespValid_SO afterwards, PTR = 0.
  - Required: the next request is served normally.
